// File: rtl/conv_via_tiling_pkg.sv
// Shared widths and helpers for the conv_via_tiling product-scaling block.
// The saturation counter exists only when CONV_VIA_TILING_SAT_CNT_EN is defined.
package conv_via_tiling_pkg;

    localparam int unsigned PROD_WIDTH_DEF = 65;
    localparam int unsigned SHIFT_DEF      = 33;
    localparam int unsigned DOUT_WIDTH_DEF = 32;
    localparam int unsigned SAT_CNT_WIDTH  = 16;

    typedef logic [SAT_CNT_WIDTH-1:0] sat_cnt_t;

    // Saturating increment; sticks at all-ones.
    function automatic sat_cnt_t sat_inc(input sat_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + sat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/conv_via_tiling_round_sat.sv
// Combinational reciprocal-product scaling: arithmetic shift with round toward
// zero, then clamp to the signed output range and flag the clamp.
module conv_via_tiling_round_sat
    import conv_via_tiling_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned SHIFT      = SHIFT_DEF,
    parameter int unsigned DOUT_WIDTH = DOUT_WIDTH_DEF
) (
    input  logic [PROD_WIDTH-1:0] din,
    output logic [DOUT_WIDTH-1:0] q,
    output logic                  sat
);

    localparam int unsigned EW = PROD_WIDTH + 1;

    logic signed [EW-1:0] one;
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] shq;
    logic signed [EW-1:0] q_max;
    logic signed [EW-1:0] q_min;

    // Negative inputs get a 2^SHIFT-1 bias so the floor shift truncates toward zero.
    always_comb begin
        one   = EW'(1);
        ext   = EW'($signed(din));
        bias  = din[PROD_WIDTH-1] ? ((one << SHIFT) - one) : '0;
        sum   = ext + bias;
        shq   = sum >>> SHIFT;
        q_max = (one << (DOUT_WIDTH - 1)) - one;
        q_min = -(one << (DOUT_WIDTH - 1));
    end

    always_comb begin
        q   = shq[DOUT_WIDTH-1:0];
        sat = 1'b0;
        if (shq > q_max) begin
            q   = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            sat = 1'b1;
        end else if (shq < q_min) begin
            q   = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/conv_via_tiling_prod_scale.sv
// Two-stage valid/ready pipeline scaling a signed reciprocal product to a
// saturated quotient. Optional saturation counter: CONV_VIA_TILING_SAT_CNT_EN.
module conv_via_tiling_prod_scale
    import conv_via_tiling_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned SHIFT      = SHIFT_DEF,
    parameter int unsigned DOUT_WIDTH = DOUT_WIDTH_DEF
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [PROD_WIDTH-1:0]    din,
    input  logic                     din_vld,
    output logic                     din_rdy,
    output logic [DOUT_WIDTH-1:0]    dout,
    output logic                     dout_vld,
    input  logic                     dout_rdy,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt
);

    logic                  s1_vld;
    logic [PROD_WIDTH-1:0] s1_data;
    logic                  adv2;
    logic                  load2;
    logic [DOUT_WIDTH-1:0] q;
    logic                  sat;

    assign adv2    = !dout_vld || dout_rdy;
    assign din_rdy = !s1_vld || adv2;
    assign load2   = adv2 && s1_vld;

    // S1: capture the product; a drain and a new load may share a cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else if (din_rdy) begin
            s1_vld <= din_vld;
            if (din_vld) begin
                s1_data <= din;
            end
        end
    end

    conv_via_tiling_round_sat #(
        .PROD_WIDTH (PROD_WIDTH),
        .SHIFT      (SHIFT),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_round_sat (
        .din (s1_data),
        .q   (q),
        .sat (sat)
    );

    // S2: output register, frozen while the consumer stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout_vld <= 1'b0;
            dout     <= '0;
        end else if (adv2) begin
            dout_vld <= s1_vld;
            if (s1_vld) begin
                dout <= q;
            end
        end
    end

`ifdef CONV_VIA_TILING_SAT_CNT_EN
    // Count clamped items as they enter S2.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_cnt <= '0;
        end else if (load2 && sat) begin
            sat_cnt <= sat_inc(sat_cnt);
        end
    end
`else
    logic sat_unused;
    logic load2_unused;
    assign sat_unused   = sat;
    assign load2_unused = load2;
    assign sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_conv_via_tiling_prod_scale.sv
// Directed and streaming checks for conv_via_tiling_prod_scale at SHIFT=33
// (default) and SHIFT=31, compared against an independent division model.
module tb_conv_via_tiling_prod_scale;

`ifdef CONV_VIA_TILING_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic signed [64:0] din;
    logic               din_vld;
    logic               din_rdy;
    logic [31:0]        dout;
    logic               dout_vld;
    logic               dout_rdy;
    logic [15:0]        sat_cnt;

    logic signed [64:0] din31;
    logic               din_vld31;
    logic               din_rdy31;
    logic [31:0]        dout31;
    logic               dout_vld31;
    logic               dout_rdy31;
    logic [15:0]        sat_cnt31;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sat31 = 0;

    always #5 ap_clk = ~ap_clk;

    conv_via_tiling_prod_scale u_dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .sat_cnt  (sat_cnt)
    );

    conv_via_tiling_prod_scale #(.SHIFT(31)) u_dut31 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .din      (din31),
        .din_vld  (din_vld31),
        .din_rdy  (din_rdy31),
        .dout     (dout31),
        .dout_vld (dout_vld31),
        .dout_rdy (dout_rdy31),
        .sat_cnt  (sat_cnt31)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Truncating signed division, then clamp to 32-bit signed.
    function automatic logic [31:0] model(input logic signed [64:0] d, input int sh);
        logic signed [65:0] e;
        logic signed [65:0] dv;
        logic signed [65:0] qq;
        e  = 66'(d);
        dv = 66'sd1 <<< sh;
        qq = e / dv;
        if (qq > 66'sd2147483647)       return 32'h7FFF_FFFF;
        else if (qq < -66'sd2147483648) return 32'h8000_0000;
        else                            return qq[31:0];
    endfunction

    // One item through both DUTs: not valid after 1 edge, valid with result after 2.
    task automatic dir(input string tag, input logic signed [64:0] d,
                       input logic [31:0] exp33, input logic [31:0] exp31, input bit sat31);
        din = d; din31 = d; din_vld = 1'b1; din_vld31 = 1'b1;
        #1;
        check({tag, "_rdy"}, 64'(din_rdy), 64'(1));
        @(posedge ap_clk);
        @(negedge ap_clk);
        din_vld = 1'b0; din_vld31 = 1'b0;
        check({tag, "_lat1"}, 64'(dout_vld), 64'(0));
        @(posedge ap_clk);
        @(negedge ap_clk);
        if (sat31) exp_sat31++;
        check({tag, "_vld"}, 64'(dout_vld), 64'(1));
        check({tag, "_q33"}, 64'(dout), 64'(exp33));
        check({tag, "_q31"}, 64'(dout31), 64'(exp31));
        check({tag, "_cnt33"}, 64'(sat_cnt), 64'(0));
        check({tag, "_cnt31"}, 64'(sat_cnt31), CNT_EN ? 64'(exp_sat31) : 64'(0));
    endtask

    initial begin
        logic signed [64:0] vec [6];
        logic [31:0]        expq [$];
        logic signed [64:0] a;
        logic signed [64:0] b;
        int sent;
        int rcvd;
        int cyc;
        bit pending;

        ap_rst_n = 1'b0; din = '0; din_vld = 1'b0; dout_rdy = 1'b1;
        din31 = '0; din_vld31 = 1'b0; dout_rdy31 = 1'b1;
        @(negedge ap_clk);
        check("rst_vld", 64'(dout_vld), 64'(0));
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_rdy", 64'(din_rdy), 64'(1));
        check("rst_cnt", 64'(sat_cnt), 64'(0));
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        dir("pos3",   65'sd25769803779,  32'd3,          32'd12,         1'b0);
        dir("neg3",  -65'sd25769803779,  32'hFFFF_FFFD,  32'hFFFF_FFF4,  1'b0);
        dir("m1",    -65'sd1,            32'd0,          32'd0,          1'b0);
        dir("p2e63",  65'h0_8000_0000_0000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1);
        dir("n2e63",  65'h1_7FFF_FFFF_FFFF_FFFF, 32'hC000_0000, 32'h8000_0000, 1'b1);
        dir("pmax",   65'h0_FFFF_FFFF_FFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        dir("nmin",   65'h1_0000_0000_0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
        dir("in31",   65'sd10737418240,  32'd1,          32'd5,          1'b0);

        // Back-to-back stream with the consumer always ready.
        vec[0] = 65'sd858993459200; vec[1] = -65'sd17179869184; vec[2] = 65'sd8589934591;
        vec[3] = -65'sd8589934593;  vec[4] = 65'sd42949672960;  vec[5] = -65'sd1099511627776;
        for (int c = 0; c < 8; c++) begin
            if (c >= 2) begin
                check("bb_vld", 64'(dout_vld), 64'(1));
                check("bb_q", 64'(dout), 64'(model(vec[c-2], 33)));
            end
            if (c < 6) begin
                din = vec[c]; din_vld = 1'b1;
                #1;
                check("bb_rdy", 64'(din_rdy), 64'(1));
            end else begin
                din_vld = 1'b0;
            end
            @(posedge ap_clk);
            @(negedge ap_clk);
        end

        // Backpressure: two items fill the pipe, a third is refused.
        a = 65'sd77309411328; b = -65'sd51539607552;
        dout_rdy = 1'b0; din = a; din_vld = 1'b1;
        @(posedge ap_clk); @(negedge ap_clk);
        din = b;
        @(posedge ap_clk); @(negedge ap_clk);
        din = 65'sd123456789012;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy", 64'(din_rdy), 64'(0));
            check("bp_vld", 64'(dout_vld), 64'(1));
            check("bp_hold", 64'(dout), 64'(32'd9));
            @(posedge ap_clk); @(negedge ap_clk);
        end
        din_vld = 1'b0; dout_rdy = 1'b1;
        check("dr_a", 64'(dout), 64'(32'd9));
        @(posedge ap_clk); @(negedge ap_clk);
        check("dr_bvld", 64'(dout_vld), 64'(1));
        check("dr_b", 64'(dout), 64'(32'hFFFF_FFFA));
        @(posedge ap_clk); @(negedge ap_clk);
        check("dr_empty", 64'(dout_vld), 64'(0));

        // Random streaming with random consumer stalls.
        sent = 0; rcvd = 0; cyc = 0; pending = 1'b0;
        while ((sent < 100 || rcvd < 100) && cyc < 3000) begin
            dout_rdy = 1'($urandom_range(0, 1));
            if (sent < 100) begin
                if (!pending) begin
                    din = 65'($signed({$urandom(), $urandom()})) >>> $urandom_range(0, 40);
                    din_vld = 1'($urandom_range(0, 3) != 0);
                    pending = din_vld;
                end
            end else begin
                din_vld = 1'b0;
            end
            #1;
            if (dout_vld && dout_rdy) begin
                if (expq.size() == 0) begin
                    check("st_extra", 64'(1), 64'(0));
                end else begin
                    check("st_q", 64'(dout), 64'(expq.pop_front()));
                end
                rcvd++;
            end
            if (din_vld && din_rdy) begin
                expq.push_back(model(din, 33));
                sent++;
                pending = 1'b0;
            end
            cyc++;
            @(posedge ap_clk); @(negedge ap_clk);
        end
        check("st_count", 64'(rcvd), 64'(100));
        din_vld = 1'b0; dout_rdy = 1'b1;
        @(posedge ap_clk); @(negedge ap_clk);

        // Reset with two items in flight.
        dout_rdy = 1'b0; din = 65'sd25769803779; din_vld = 1'b1;
        @(posedge ap_clk); @(negedge ap_clk);
        din = 65'sd51539607552;
        @(posedge ap_clk); @(negedge ap_clk);
        din_vld = 1'b0;
        #1;
        check("rf_full", 64'(din_rdy), 64'(0));
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("rf_vld", 64'(dout_vld), 64'(0));
        check("rf_dout", 64'(dout), 64'(0));
        check("rf_rdy", 64'(din_rdy), 64'(1));
        check("rf_cnt31", 64'(sat_cnt31), 64'(0));
        @(negedge ap_clk);
        ap_rst_n = 1'b1; dout_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge ap_clk); @(negedge ap_clk);
            check("rf_stale", 64'(dout_vld), 64'(0));
        end
        check("rf_cnt", 64'(sat_cnt), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
